// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - register offsets and CTRL bit positions for the timer array
package timer_pkg;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_LOAD_L = 3'd1;
  localparam logic [2:0] REG_VAL_L  = 3'd2;
  localparam logic [2:0] REG_LOAD_H = 3'd3;
  localparam logic [2:0] REG_VAL_H  = 3'd4;
  localparam logic [2:0] REG_PRESC  = 3'd5;
  localparam logic [2:0] REG_GSTAT  = 3'd6;
  localparam logic [2:0] REG_RSVD   = 3'd7;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_IE      = 1;
  localparam int CTRL_ONESHOT = 2;
  localparam int CTRL_FLAG    = 16;

endpackage

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one prescaled down-counter with periodic/one-shot mode and sticky flag
module timer_channel #(
  parameter int CNT_W   = 64,
  parameter int PRESC_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_ctrl,
  input  logic        wr_load_l,
  input  logic        wr_load_h,
  input  logic        wr_presc,
  input  logic        wr_reload,
  input  logic        rd_ctrl,
  input  logic [2:0]  reg_sel,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        flag,
  output logic        irq
);
  import timer_pkg::*;

  logic               en, ie, oneshot;
  logic [CNT_W-1:0]   load, val;
  logic [PRESC_W-1:0] presc, presc_cnt;
  logic [63:0]        load_ext, val_ext, load_wr;
  logic               tick;

  // Zero-extended views make bits at or above CNT_W read back as 0 for free.
  assign load_ext = 64'(load);
  assign val_ext  = 64'(val);
  assign tick     = en && (presc_cnt == presc);
  assign irq      = flag && ie;

  always_comb begin
    load_wr = load_ext;
    if (wr_load_l) load_wr[31:0]  = wdata;
    if (wr_load_h) load_wr[63:32] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en        <= 1'b0;
      ie        <= 1'b0;
      oneshot   <= 1'b0;
      load      <= '0;
      val       <= '0;
      presc     <= '0;
      presc_cnt <= '0;
      flag      <= 1'b0;
    end else begin
      if (wr_load_l || wr_load_h) load <= load_wr[CNT_W-1:0];
      if (wr_presc) presc <= wdata[PRESC_W-1:0];
      if (wr_ctrl) begin
        en      <= wdata[CTRL_EN];
        ie      <= wdata[CTRL_IE];
        oneshot <= wdata[CTRL_ONESHOT];
      end
      // Manual reload overrides any tick or flag set on the same edge.
      if (wr_reload) begin
        val       <= load;
        flag      <= 1'b0;
        presc_cnt <= '0;
      end else begin
        if (rd_ctrl) flag <= 1'b0;
        if (!en || wr_presc || tick) presc_cnt <= '0;
        else                         presc_cnt <= presc_cnt + PRESC_W'(1);
        if (tick) begin
          if (val != '0) begin
            val <= val - CNT_W'(1);
          end else begin
            flag <= 1'b1;
            if (oneshot) en  <= 1'b0;
            else         val <= load;
          end
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_CTRL: begin
        rdata[CTRL_EN]      = en;
        rdata[CTRL_IE]      = ie;
        rdata[CTRL_ONESHOT] = oneshot;
        rdata[CTRL_FLAG]    = flag;
      end
      REG_LOAD_L: rdata = load_ext[31:0];
      REG_VAL_L:  rdata = val_ext[31:0];
      REG_LOAD_H: rdata = load_ext[63:32];
      REG_VAL_H:  rdata = val_ext[63:32];
      REG_PRESC:  rdata = 32'(presc);
      default:    rdata = '0;
    endcase
  end

endmodule

// File: rtl/timer_array.sv
// rtl/timer_array.sv - NUM_CH timer channels behind one register window with combined irq
module timer_array #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 64,
  parameter int PRESC_W = 8,
  parameter int ADDR_W  = 3 + $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sel,
  input  logic              wen,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic [NUM_CH-1:0] irq_ch,
  output logic              irq
);
  import timer_pkg::*;

  logic [31:0]       ch_idx;
  logic [2:0]        reg_sel;
  logic              ch_valid, wr_acc, rd_acc, is_reload;
  logic [NUM_CH-1:0] flags;
  logic [31:0]       chan_rdata [NUM_CH];

  assign ch_idx    = 32'(addr >> 3);
  assign reg_sel   = addr[2:0];
  assign ch_valid  = ch_idx < 32'(NUM_CH);
  assign wr_acc    = sel && wen && ch_valid;
  assign rd_acc    = sel && !wen && ch_valid;
  assign is_reload = (reg_sel == REG_VAL_L) || (reg_sel == REG_VAL_H);
  assign irq       = |irq_ch;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic hit;
    assign hit = ch_idx == 32'(i);

    timer_channel #(.CNT_W(CNT_W), .PRESC_W(PRESC_W)) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_ctrl   (hit && wr_acc && reg_sel == REG_CTRL),
      .wr_load_l (hit && wr_acc && reg_sel == REG_LOAD_L),
      .wr_load_h (hit && wr_acc && reg_sel == REG_LOAD_H),
      .wr_presc  (hit && wr_acc && reg_sel == REG_PRESC),
      .wr_reload (hit && wr_acc && is_reload),
      .rd_ctrl   (hit && rd_acc && reg_sel == REG_CTRL),
      .reg_sel   (reg_sel),
      .wdata     (wdata),
      .rdata     (chan_rdata[i]),
      .flag      (flags[i]),
      .irq       (irq_ch[i])
    );
  end

  // GSTAT is visible from every channel window; out-of-range channels read 0.
  always_comb begin
    rdata = '0;
    if (ch_valid) begin
      if (reg_sel == REG_GSTAT) begin
        rdata = 32'(flags);
      end else if (reg_sel != REG_RSVD) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (ch_idx == 32'(i)) rdata = chan_rdata[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_timer_array.sv
// tb/tb_timer_array.sv - directed scoreboard bench for timer_array
module tb_timer_array;
  import timer_pkg::*;

  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 64;
  localparam int PRESC_W = 8;
  localparam int ADDR_W  = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sel = 1'b0;
  logic              wen = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [31:0]       wdata = '0;
  logic [31:0]       rdata;
  logic [NUM_CH-1:0] irq_ch;
  logic              irq;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  timer_array #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESC_W(PRESC_W), .ADDR_W(ADDR_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sel    (sel),
    .wen    (wen),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .irq_ch (irq_ch),
    .irq    (irq)
  );

  function automatic logic [ADDR_W-1:0] a(input int ch, input logic [2:0] r);
    return ADDR_W'(ch * 8) | ADDR_W'(r);
  endfunction

  task automatic push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL sb_empty: observed %h expected none", obs);
      return;
    end
    e = sb.pop_front();
    vectors++;
    assert (obs === e.exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
    end
  endtask

  task automatic wr(input int ch, input logic [2:0] r, input logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; wen = 1'b1; addr = a(ch, r); wdata = d;
    @(posedge clk);
    #1 sel = 1'b0; wen = 1'b0;
  endtask

  task automatic rd(input int ch, input logic [2:0] r, input logic [31:0] exp, input string tag);
    @(negedge clk);
    sel = 1'b1; wen = 1'b0; addr = a(ch, r);
    push(tag, exp);
    #2 pop_check(rdata);
    @(posedge clk);
    #1 sel = 1'b0;
  endtask

  task automatic chk_irq(input string tag, input logic [4:0] exp);
    push(tag, 32'(exp));
    pop_check(32'({irq, irq_ch}));
  endtask

  task automatic check_zero(input string tag);
    chk_irq({tag, "_irq"}, 5'b0);
    for (int c = 0; c < NUM_CH; c++) begin
      for (int r = 0; r < 8; r++) begin
        sel = 1'b1; wen = 1'b0; addr = a(c, 3'(r));
        push($sformatf("%s_ch%0d_r%0d", tag, c, r), 32'h0);
        #1 pop_check(rdata);
      end
    end
    sel = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    #12;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    check_zero("post_reset");

    // 64-bit load and manual reload on ch0
    wr(0, REG_LOAD_L, 32'h2345_6789);
    wr(0, REG_LOAD_H, 32'h1);
    wr(0, REG_VAL_L, 32'h0);
    rd(0, REG_VAL_L, 32'h2345_6789, "ch0_val_l");
    rd(0, REG_VAL_H, 32'h1, "ch0_val_h");
    rd(0, REG_CTRL, 32'h0, "ch0_ctrl");

    // Periodic with IE on ch1: flag on 4th clock after enable
    wr(1, REG_LOAD_L, 32'd3);
    wr(1, REG_PRESC, 32'd0);
    wr(1, REG_VAL_L, 32'h0);
    wr(1, REG_CTRL, 32'h3);
    repeat (3) @(posedge clk);
    #1 chk_irq("ch1_irq_e3", 5'b0_0000);
    @(posedge clk);
    #1 chk_irq("ch1_irq_e4", 5'b1_0010);
    rd(1, REG_CTRL, 32'h0001_0003, "ch1_ctrl_flag");
    rd(1, REG_CTRL, 32'h0000_0003, "ch1_ctrl_clr");
    chk_irq("ch1_irq_clr", 5'b0_0000);
    wr(1, REG_CTRL, 32'h0);

    // One-shot on ch2: three ticks, then stopped
    wr(2, REG_LOAD_L, 32'd2);
    wr(2, REG_VAL_L, 32'h0);
    wr(2, REG_CTRL, 32'h7);
    repeat (2) @(posedge clk);
    #1 chk_irq("ch2_irq_e2", 5'b0_0000);
    @(posedge clk);
    #1 chk_irq("ch2_irq_e3", 5'b1_0100);
    repeat (5) @(posedge clk);
    rd(2, REG_CTRL, 32'h0001_0006, "ch2_ctrl");
    rd(2, REG_VAL_L, 32'h0, "ch2_val_l");
    repeat (10) @(posedge clk);
    rd(2, REG_GSTAT, 32'h0, "ch2_no_reflag");

    // Prescaled ch3: flag exactly 8 clocks after enable, IE off
    wr(3, REG_PRESC, 32'd3);
    wr(3, REG_LOAD_L, 32'd1);
    wr(3, REG_VAL_L, 32'h0);
    wr(3, REG_CTRL, 32'h1);
    sel = 1'b1; wen = 1'b0; addr = a(3, REG_GSTAT);
    repeat (7) @(posedge clk);
    #1 push("ch3_gstat_e7", 32'h0);
    pop_check(rdata);
    @(posedge clk);
    #1 push("ch3_gstat_e8", 32'h8);
    pop_check(rdata);
    chk_irq("ch3_irq_masked", 5'b0_0000);
    sel = 1'b0;
    wr(3, REG_CTRL, 32'h0);
    rd(3, REG_CTRL, 32'h0001_0000, "ch3_ctrl");

    // Collision: CTRL read on the terminal-tick edge keeps the flag
    wr(1, REG_VAL_L, 32'h0);
    wr(1, REG_CTRL, 32'h3);
    repeat (3) @(posedge clk);
    rd(1, REG_CTRL, 32'h0000_0003, "col_rd_pre");
    rd(1, REG_CTRL, 32'h0001_0003, "col_rd_keep");
    // Collision: VAL write on the next terminal-tick edge wins over the flag set
    repeat (2) @(posedge clk);
    wr(1, REG_VAL_L, 32'hFFFF_FFFF);
    chk_irq("col_val_irq", 5'b0_0000);
    rd(1, REG_VAL_L, 32'd3, "col_val_reload");
    rd(1, REG_CTRL, 32'h0000_0003, "col_val_noflag");
    wr(1, REG_CTRL, 32'h0);

    // Reset asserted mid-count with a pending interrupt
    wr(0, REG_LOAD_H, 32'h0);
    wr(0, REG_LOAD_L, 32'd1);
    wr(0, REG_VAL_L, 32'h0);
    wr(0, REG_CTRL, 32'h3);
    repeat (4) @(posedge clk);
    #1 chk_irq("pre_rst_irq", 5'b1_0001);
    #1 rst_n = 1'b0;
    #1 check_zero("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
